// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: opcodes, class and state
// enums, and the default datapath geometry.
// Optional feature macro: ALU_OVERFLOW_EN (adds the registered ovf flag).
package alu_pkg;

  localparam int ALU_WIDTH   = 16;
  localparam int ALU_SHAMT_W = 4;

  // Opcodes that resolve to an add.
  localparam logic [3:0] OP_ADD0 = 4'b0000;
  localparam logic [3:0] OP_ADD1 = 4'b0100;
  localparam logic [3:0] OP_ADD2 = 4'b0110;
  localparam logic [3:0] OP_ADD3 = 4'b1000;
  localparam logic [3:0] OP_ADD4 = 4'b1001;
  localparam logic [3:0] OP_ADD5 = 4'b1010;
  localparam logic [3:0] OP_ADD6 = 4'b1011;

  // Opcodes that resolve to in0 - in1.
  localparam logic [3:0] OP_SUB0 = 4'b0001;
  localparam logic [3:0] OP_SUB1 = 4'b0010;
  localparam logic [3:0] OP_SUB2 = 4'b0011;
  localparam logic [3:0] OP_SUB3 = 4'b0101;
  localparam logic [3:0] OP_SUB4 = 4'b1100;

  localparam logic [3:0] OP_AND  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b1110;
  localparam logic [3:0] OP_SLL  = 4'b1111;

  typedef enum logic [2:0] {
    CLS_ADD,
    CLS_SUB,
    CLS_AND,
    CLS_OR,
    CLS_SLL
  } alu_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between issue logic (master) and the ALU (slave).
// Optional feature macro: ALU_OVERFLOW_EN (adds ovf to the response side).
interface alu_exec_unit_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             req_valid;
  logic             req_ready;
  logic [3:0]       inst_id;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             pos;
`ifdef ALU_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output req_valid, inst_id, in0, in1, resp_ready,
`ifdef ALU_OVERFLOW_EN
    input  ovf,
`endif
    input  req_ready, resp_valid, out, zero, pos
  );

  modport slave (
    input  req_valid, inst_id, in0, in1, resp_ready,
`ifdef ALU_OVERFLOW_EN
    output ovf,
`endif
    output req_ready, resp_valid, out, zero, pos
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: maps the 4-bit inst_id onto an ALU class.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0] inst_id,
  output alu_class_e op_class
);

  // Opcode 0111 is unassigned; it falls through to add so the unit never stalls.
  always_comb begin
    op_class = CLS_ADD;
    case (inst_id)
      OP_ADD0, OP_ADD1, OP_ADD2, OP_ADD3,
      OP_ADD4, OP_ADD5, OP_ADD6:           op_class = CLS_ADD;
      OP_SUB0, OP_SUB1, OP_SUB2,
      OP_SUB3, OP_SUB4:                    op_class = CLS_SUB;
      OP_AND:                              op_class = CLS_AND;
      OP_OR:                               op_class = CLS_OR;
      OP_SLL:                              op_class = CLS_SLL;
      default:                             op_class = CLS_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU responder: single-cycle add/sub/and/or, iterative shift-left
// (one bit per cycle), result held with zero/pos flags until accepted.
// Optional feature macro: ALU_OVERFLOW_EN (registered signed-overflow flag).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);

  alu_state_e         state_reg;
  alu_state_e         state_next;
  alu_class_e         op_class;
  logic [WIDTH-1:0]   acc_reg;
  logic [SHAMT_W-1:0] cnt_reg;
  logic [WIDTH-1:0]   out_reg;
  logic               zero_reg;
  logic               pos_reg;
  logic [SHAMT_W-1:0] shamt;
  logic               req_fire;
  logic               resp_fire;
  logic               shift_start;
  logic               shift_last;
  logic [WIDTH-1:0]   alu_res;
  logic               wr_en;
  logic [WIDTH-1:0]   wr_val;

  alu_op_decode u_decode (
    .inst_id  (bus.inst_id),
    .op_class (op_class)
  );

  assign shamt       = bus.in1[SHAMT_W-1:0];
  assign req_fire    = bus.req_valid && bus.req_ready;
  assign resp_fire   = bus.resp_valid && bus.resp_ready;
  assign shift_start = req_fire && (op_class == CLS_SLL) && (shamt != '0);
  assign shift_last  = (state_reg == ST_SHIFT) && (cnt_reg == SHAMT_W'(1));

  // State register; reset abandons any in-flight or unaccepted result.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req_fire)   state_next = shift_start ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (shift_last) state_next = ST_DONE;
      ST_DONE:  if (resp_fire)  state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs; both held low while reset is asserted.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    if (!reset) begin
      bus.req_ready  = (state_reg == ST_IDLE);
      bus.resp_valid = (state_reg == ST_DONE);
    end
  end

  // Single-cycle result; shift-by-zero passes in0 straight through.
  always_comb begin
    alu_res = bus.in0;
    case (op_class)
      CLS_ADD: alu_res = bus.in0 + bus.in1;
      CLS_SUB: alu_res = bus.in0 - bus.in1;
      CLS_AND: alu_res = bus.in0 & bus.in1;
      CLS_OR:  alu_res = bus.in0 | bus.in1;
      default: alu_res = bus.in0;
    endcase
  end

  // Select when and what to write into the result register.
  always_comb begin
    wr_en  = 1'b0;
    wr_val = alu_res;
    if (req_fire && !shift_start) begin
      wr_en = 1'b1;
    end else if (shift_last) begin
      wr_en  = 1'b1;
      wr_val = acc_reg << 1;
    end
  end

  // Shift accumulator/counter and result register with its derived flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg  <= '0;
      cnt_reg  <= '0;
      out_reg  <= '0;
      zero_reg <= 1'b0;
      pos_reg  <= 1'b0;
    end else begin
      if (shift_start) begin
        acc_reg <= bus.in0;
        cnt_reg <= shamt;
      end else if (state_reg == ST_SHIFT) begin
        acc_reg <= acc_reg << 1;
        cnt_reg <= cnt_reg - SHAMT_W'(1);
      end
      if (wr_en) begin
        out_reg  <= wr_val;
        zero_reg <= (wr_val == '0);
        pos_reg  <= !wr_val[WIDTH-1] && (wr_val != '0);
      end
    end
  end

  assign bus.out  = out_reg;
  assign bus.zero = zero_reg;
  assign bus.pos  = pos_reg;

`ifdef ALU_OVERFLOW_EN
  logic ovf_reg;
  logic ovf_calc;

  // Signed overflow: the result sign disagrees with what the operand signs allow.
  always_comb begin
    ovf_calc = 1'b0;
    case (op_class)
      CLS_ADD: ovf_calc = (bus.in0[WIDTH-1] == bus.in1[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.in0[WIDTH-1]);
      CLS_SUB: ovf_calc = (bus.in0[WIDTH-1] != bus.in1[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.in0[WIDTH-1]);
      default: ovf_calc = 1'b0;
    endcase
  end

  // Overflow flag is written together with out; shifts always clear it.
  always_ff @(posedge clk) begin
    if (reset)      ovf_reg <= 1'b0;
    else if (wr_en) ovf_reg <= shift_last ? 1'b0 : ovf_calc;
  end

  assign bus.ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed cases followed by random traffic
// under random response backpressure, checked against an arithmetic model.
module tb_alu_exec_unit;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        zero;
    logic        pos;
    logic        ovf;
    int          lat;
    int          h;
    int          due;
  } exp_t;

  logic clk;
  logic reset;
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;
  int   rr_mode = 0;
  exp_t exp_q[$];

  logic [3:0] ops [15] = '{4'b0000, 4'b0100, 4'b0110, 4'b1000, 4'b1001,
                           4'b1010, 4'b1011, 4'b0001, 4'b0010, 4'b0011,
                           4'b0101, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
  logic [15:0] corners [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

  alu_exec_unit_if #(.WIDTH(16)) bus ();

  alu_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: plain integer arithmetic modulo 2^16.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint ua, ub, sa, sb, s, r;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    e.ovf = 1'b0;
    e.lat = 1;
    if (op inside {4'b0000, 4'b0100, 4'b0110, 4'b1000, 4'b1001, 4'b1010, 4'b1011}) begin
      r = (ua + ub) % 65536;
      s = sa + sb;
      e.ovf = (s > 32767) || (s < -32768);
    end else if (op inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1100}) begin
      r = (ua - ub + 65536) % 65536;
      s = sa - sb;
      e.ovf = (s > 32767) || (s < -32768);
    end else if (op == 4'b1101) begin
      r = ua & ub;
    end else if (op == 4'b1110) begin
      r = ua | ub;
    end else begin
      r = (ua * (longint'(1) << (ub % 16))) % 65536;
      e.lat = int'(ub % 16) + 1;
    end
    e.op   = op;
    e.a    = a;
    e.b    = b;
    e.out  = r[15:0];
    e.zero = (r == 0);
    e.pos  = (r > 0) && (r < 32768);
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.inst_id   = op;
    bus.in0       = a;
    bus.in1       = b;
    guard = 0;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      chk("req_accept_timeout", 32'(bus.req_ready), 32'd1);
    end else begin
      e     = model(op, a, b);
      e.h   = cycle + 1;
      e.due = cycle + e.lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.inst_id   = 4'($urandom);
    bus.in0       = 16'($urandom);
    bus.in1       = 16'($urandom);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  function automatic logic [15:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  // Response-ready driver: always ready, random, or held off.
  always @(negedge clk) begin
    case (rr_mode)
      0:       bus.resp_ready = 1'b1;
      1:       bus.resp_ready = ($urandom_range(0, 2) != 0);
      default: bus.resp_ready = 1'b0;
    endcase
  end

  // Monitor: checks readiness, latency and held results; pops on acceptance.
  always begin : monitor
    logic first_seen;
    logic exp_ready;
    exp_t e;
    first_seen = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        first_seen = 1'b0;
      end else begin
        exp_ready = !(exp_q.size() > 0 && exp_q[0].h <= cycle);
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        if (bus.resp_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp_valid", 32'(bus.resp_valid), 32'd0);
          end else begin
            e = exp_q[0];
            if (!first_seen) begin
              first_seen = 1'b1;
              chk("latency", 32'(cycle), 32'(e.due));
            end
            chk("out", 32'(bus.out), 32'(e.out));
            chk("zero", 32'(bus.zero), 32'(e.zero));
            chk("pos", 32'(bus.pos), 32'(e.pos));
`ifdef ALU_OVERFLOW_EN
            chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
            if (bus.resp_ready) begin
              $display("txn op=%b in0=%h in1=%h out=%h zero=%b pos=%b exp=%h cycle=%0d",
                       e.op, e.a, e.b, bus.out, bus.zero, bus.pos, e.out, cycle);
              void'(exp_q.pop_front());
              first_seen = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.inst_id   = 4'd0;
    bus.in0       = 16'd0;
    bus.in1       = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("req_ready_in_reset", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_out", 32'(bus.out), 32'd0);
    chk("reset_zero", 32'(bus.zero), 32'd0);
    chk("reset_pos", 32'(bus.pos), 32'd0);
    chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);

    // Directed cases.
    issue(4'b0000, 16'h0001, 16'h0001);
    issue(4'b0001, 16'h0001, 16'h0001);
    issue(4'b0101, 16'h0000, 16'h0001);
    issue(4'b1111, 16'h0003, 16'h0005);
    issue(4'b1111, 16'h0003, 16'h0000);
    issue(4'b1111, 16'h0001, 16'h000F);
    wait_idle();

    // Backpressure: result held while a competing request is ignored.
    rr_mode = 2;
    issue(4'b0000, 16'h7FFF, 16'h0001);
    repeat (4) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.inst_id   = 4'b1101;
      bus.in0       = 16'($urandom);
      bus.in1       = 16'($urandom);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    rr_mode = 0;
    wait_idle();

    // Reset in the middle of a long shift.
    issue(4'b1111, 16'h1234, 16'h000A);
    repeat (2) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("req_ready_mid_reset", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("post_reset_out", 32'(bus.out), 32'd0);
    chk("post_reset_req_ready", 32'(bus.req_ready), 32'd1);
    issue(4'b1101, 16'h0F0F, 16'h00FF);
    wait_idle();

    // Random traffic with occasional backpressure and idle gaps.
    for (int i = 0; i < 160; i++) begin
      if (i % 20 == 0) rr_mode = $urandom_range(0, 1);
      issue(ops[$urandom_range(0, 14)], pick_operand(), pick_operand());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rr_mode = 0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
